// File: rtl/mx_reg_pkg.sv
// Shared definitions for the data-mux / register-file load path:
// loader FSM state encoding and the common load-address width.
package mx_reg_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage : mx_reg_pkg

// File: rtl/line_loader_if.sv
// Word-wide write bus from the line loader into the register file.
// The master drives the strobe, address and data; the slave answers with ready.
interface line_loader_if #(
  parameter int WORD_LENGTH = 8
) ();

  logic                          wr_en;
  logic                          wr_ready;
  logic [mx_reg_pkg::ADDR_W-1:0] wr_addr;
  logic [WORD_LENGTH-1:0]        wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface : line_loader_if

// File: rtl/line_loader.sv
// Snapshots one mux line and replays it as DEPTH consecutive single-word
// writes into the register file under a ready/enable handshake.
module line_loader
  import mx_reg_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [DEPTH-1:0][WORD_LENGTH-1:0]   line_data,
  input  logic [ADDR_W-1:0]                   line_addr,
  input  logic                                load_req,
  line_loader_if.master                       wr_if,
  output logic                                busy,
  output logic                                done
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  loader_state_e                     r_state;
  loader_state_e                     w_next_state;
  logic [DEPTH-1:0][WORD_LENGTH-1:0] r_shadow;
  logic [ADDR_W-1:0]                 r_addr;
  logic [IDX_W-1:0]                  r_index;

  logic w_capture;
  logic w_accept;
  logic w_last;

  assign w_capture = (r_state == IDLE) && load_req;
  assign w_accept  = (r_state == LOAD) && wr_if.wr_ready;
  assign w_last    = w_accept && (r_index == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block is defaulted first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    wr_if.wr_en   = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load_req) w_next_state = LOAD;
      end
      LOAD: begin
        wr_if.wr_en = 1'b1;
        busy        = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: the shadow buffer is reset on purpose so wr_data reads zero out of
  // reset; it is a small flop array, not an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_addr   <= '0;
      r_index  <= '0;
    end else if (w_capture) begin
      r_shadow <= line_data;
      r_addr   <= line_addr;
      r_index  <= '0;
    end else if (w_accept) begin
      r_addr  <= r_addr + 1'b1;
      // Wrap explicitly so a non-power-of-two DEPTH never indexes past the line.
      r_index <= w_last ? '0 : r_index + 1'b1;
    end
  end

  assign wr_if.wr_addr = r_addr;
  assign wr_if.wr_data = r_shadow[r_index];

endmodule : line_loader

// File: tb/tb_line_loader.sv
// Directed bench for line_loader: reset, basic load, wrap, backpressure,
// snapshot/ignore, mid-operation reset and back-to-back requests.
module tb_line_loader;

  localparam int WL    = 8;
  localparam int DEPTH = 16;

  logic                        clk;
  logic                        rst_n;
  logic [DEPTH-1:0][WL-1:0]    line_data;
  logic [7:0]                  line_addr;
  logic                        load_req;
  logic                        busy;
  logic                        done;

  line_loader_if #(.WORD_LENGTH(WL)) wr_bus ();

  line_loader #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_data (line_data),
    .line_addr (line_addr),
    .load_req  (load_req),
    .wr_if     (wr_bus.master),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Monitor: accepted writes, stalled writes, busy cycles and done pulses.
  logic [7:0]  q_addr[$];
  logic [7:0]  q_data[$];
  int          q_cyc[$];
  logic [7:0]  s_addr[$];
  logic [7:0]  s_data[$];
  int          d_cyc[$];
  int          busy_cnt = 0;

  always @(negedge clk) begin
    if (wr_bus.wr_en && wr_bus.wr_ready) begin
      q_addr.push_back(wr_bus.wr_addr);
      q_data.push_back(wr_bus.wr_data);
      q_cyc.push_back(cyc);
    end
    if (wr_bus.wr_en && !wr_bus.wr_ready) begin
      s_addr.push_back(wr_bus.wr_addr);
      s_data.push_back(wr_bus.wr_data);
    end
    if (busy) busy_cnt = busy_cnt + 1;
    if (done) d_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int target, input string name);
    int budget = 60;
    while (d_cyc.size() < target && budget > 0) begin
      tick();
      budget--;
    end
    tests_run++;
    if (d_cyc.size() < target) begin
      tests_failed++;
      $display("FAIL %s_timeout: done pulses %0d, required %0d", name, d_cyc.size(), target);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    load_req  = 1'b0;
    line_addr = 8'h00;
    line_data = '0;
    wr_bus.wr_ready = 1'b1;
    #1;
    tests_run++;
    if ({wr_bus.wr_en, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b required 000", {wr_bus.wr_en, busy, done});
    end
    tests_run++;
    if ({wr_bus.wr_addr, wr_bus.wr_data} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_bus: got %h required 0000", {wr_bus.wr_addr, wr_bus.wr_data});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({wr_bus.wr_en, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b required 000", {wr_bus.wr_en, busy, done});
    end
  endtask

  task automatic test_basic();
    int q0 = q_addr.size();
    int d0 = d_cyc.size();
    int b0 = busy_cnt;
    int n;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(8'hA0 + k);
    line_addr = 8'h10;
    load_req  = 1'b1;
    tick();
    n = cyc;
    load_req = 1'b0;
    wait_done(d0 + 1, "basic");
    tests_run++;
    if (q_addr.size() - q0 !== DEPTH) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d writes required %0d", q_addr.size() - q0, DEPTH);
    end
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (q0 + k >= q_addr.size()) begin
        tests_failed++;
        $display("FAIL basic_word%0d: missing write", k);
      end else if ({q_addr[q0+k], q_data[q0+k], q_cyc[q0+k]} !== {8'(8'h10 + k), 8'(8'hA0 + k), n + k}) begin
        tests_failed++;
        $display("FAIL basic_word%0d: got addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                 k, q_addr[q0+k], q_data[q0+k], q_cyc[q0+k], 8'(8'h10 + k), 8'(8'hA0 + k), n + k);
      end
    end
    tests_run++;
    if (d_cyc.size() != d0 + 1 || d_cyc[d0] != n + DEPTH) begin
      tests_failed++;
      $display("FAIL basic_done: got %0d pulses (first at %0d) required 1 at %0d",
               d_cyc.size() - d0, (d_cyc.size() > d0) ? d_cyc[d0] : -1, n + DEPTH);
    end
    tests_run++;
    if (busy_cnt - b0 !== DEPTH) begin
      tests_failed++;
      $display("FAIL basic_busy: got %0d cycles required %0d", busy_cnt - b0, DEPTH);
    end
  endtask

  task automatic test_wrap();
    int q0 = q_addr.size();
    int d0 = d_cyc.size();
    int n;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(k);
    line_addr = 8'hFE;
    load_req  = 1'b1;
    tick();
    n = cyc;
    load_req = 1'b0;
    wait_done(d0 + 1, "wrap");
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (q0 + k >= q_addr.size()) begin
        tests_failed++;
        $display("FAIL wrap_word%0d: missing write", k);
      end else if ({q_addr[q0+k], q_data[q0+k], q_cyc[q0+k]} !== {8'(8'hFE + k), 8'(k), n + k}) begin
        tests_failed++;
        $display("FAIL wrap_word%0d: got addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                 k, q_addr[q0+k], q_data[q0+k], q_cyc[q0+k], 8'(8'hFE + k), 8'(k), n + k);
      end
    end
    tests_run++;
    if (q_addr.size() - q0 !== DEPTH) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d writes required %0d", q_addr.size() - q0, DEPTH);
    end
  endtask

  task automatic test_backpressure();
    int q0 = q_addr.size();
    int s0 = s_addr.size();
    int d0 = d_cyc.size();
    int b0 = busy_cnt;
    int n;
    int exp_cyc;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(8'h30 + k);
    line_addr = 8'h20;
    load_req  = 1'b1;
    tick();
    n = cyc;
    load_req = 1'b0;
    repeat (5) tick();
    wr_bus.wr_ready = 1'b0;
    repeat (3) tick();
    wr_bus.wr_ready = 1'b1;
    wait_done(d0 + 1, "bp");
    tests_run++;
    if (s_addr.size() - s0 !== 3) begin
      tests_failed++;
      $display("FAIL bp_stalls: got %0d stall cycles required 3", s_addr.size() - s0);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (s0 + i >= s_addr.size()) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: missing stall sample", i);
      end else if ({s_addr[s0+i], s_data[s0+i]} !== 16'h2535) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got %h required 2535", i, {s_addr[s0+i], s_data[s0+i]});
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      exp_cyc = (k < 5) ? n + k : n + k + 3;
      tests_run++;
      if (q0 + k >= q_addr.size()) begin
        tests_failed++;
        $display("FAIL bp_word%0d: missing write", k);
      end else if ({q_addr[q0+k], q_data[q0+k], q_cyc[q0+k]} !== {8'(8'h20 + k), 8'(8'h30 + k), exp_cyc}) begin
        tests_failed++;
        $display("FAIL bp_word%0d: got addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                 k, q_addr[q0+k], q_data[q0+k], q_cyc[q0+k], 8'(8'h20 + k), 8'(8'h30 + k), exp_cyc);
      end
    end
    tests_run++;
    if (d_cyc.size() != d0 + 1 || d_cyc[d0] != n + DEPTH + 3) begin
      tests_failed++;
      $display("FAIL bp_done: got %0d pulses required 1 at %0d", d_cyc.size() - d0, n + DEPTH + 3);
    end
    tests_run++;
    if (busy_cnt - b0 !== DEPTH + 3) begin
      tests_failed++;
      $display("FAIL bp_busy: got %0d cycles required %0d", busy_cnt - b0, DEPTH + 3);
    end
  endtask

  task automatic test_snapshot();
    int q0 = q_addr.size();
    int d0 = d_cyc.size();
    int n;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(8'h60 + k);
    line_addr = 8'h50;
    load_req  = 1'b1;
    tick();
    n = cyc;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'hEE;
    line_addr = 8'h99;
    tick();
    load_req = 1'b0;
    repeat (6) tick();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    wait_done(d0 + 1, "snap");
    repeat (4) tick();
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (q0 + k >= q_addr.size()) begin
        tests_failed++;
        $display("FAIL snap_word%0d: missing write", k);
      end else if ({q_addr[q0+k], q_data[q0+k], q_cyc[q0+k]} !== {8'(8'h50 + k), 8'(8'h60 + k), n + k}) begin
        tests_failed++;
        $display("FAIL snap_word%0d: got addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                 k, q_addr[q0+k], q_data[q0+k], q_cyc[q0+k], 8'(8'h50 + k), 8'(8'h60 + k), n + k);
      end
    end
    tests_run++;
    if (q_addr.size() - q0 !== DEPTH || d_cyc.size() - d0 !== 1) begin
      tests_failed++;
      $display("FAIL snap_single_op: got %0d writes %0d dones required %0d writes 1 done",
               q_addr.size() - q0, d_cyc.size() - d0, DEPTH);
    end
  endtask

  task automatic test_reset_midop();
    int q0 = q_addr.size();
    int d0 = d_cyc.size();
    int n;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(8'h80 + k);
    line_addr = 8'h70;
    load_req  = 1'b1;
    tick();
    load_req = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wr_bus.wr_en, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_ctl: got %b required 000", {wr_bus.wr_en, busy, done});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (q_addr.size() - q0 !== 4 || d_cyc.size() != d0) begin
      tests_failed++;
      $display("FAIL midrst_abort: got %0d writes %0d dones required 4 writes 0 dones",
               q_addr.size() - q0, d_cyc.size() - d0);
    end
    q0 = q_addr.size();
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(8'hC0 + k);
    line_addr = 8'h40;
    load_req  = 1'b1;
    tick();
    n = cyc;
    load_req = 1'b0;
    wait_done(d0 + 1, "midrst");
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (q0 + k >= q_addr.size()) begin
        tests_failed++;
        $display("FAIL midrst_word%0d: missing write", k);
      end else if ({q_addr[q0+k], q_data[q0+k], q_cyc[q0+k]} !== {8'(8'h40 + k), 8'(8'hC0 + k), n + k}) begin
        tests_failed++;
        $display("FAIL midrst_word%0d: got addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                 k, q_addr[q0+k], q_data[q0+k], q_cyc[q0+k], 8'(8'h40 + k), 8'(8'hC0 + k), n + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    int q0 = q_addr.size();
    int d0 = d_cyc.size();
    int n;
    int idx;
    for (int k = 0; k < DEPTH; k++) line_data[k] = 8'(8'h10 * (k % 16) + 8'h05);
    line_addr = 8'hE0;
    load_req  = 1'b1;
    tick();
    n = cyc;
    repeat (19) tick();
    load_req = 1'b0;
    wait_done(d0 + 2, "b2b");
    repeat (4) tick();
    tests_run++;
    if (q_addr.size() - q0 !== 2 * DEPTH) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d writes required %0d", q_addr.size() - q0, 2 * DEPTH);
    end
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = q0 + j * DEPTH + k;
        tests_run++;
        if (idx >= q_addr.size()) begin
          tests_failed++;
          $display("FAIL b2b_op%0d_word%0d: missing write", j, k);
        end else if ({q_addr[idx], q_data[idx], q_cyc[idx]} !==
                     {8'(8'hE0 + k), 8'(8'h10 * k + 8'h05), n + (DEPTH + 2) * j + k}) begin
          tests_failed++;
          $display("FAIL b2b_op%0d_word%0d: got addr %h data %h cyc %0d required addr %h data %h cyc %0d",
                   j, k, q_addr[idx], q_data[idx], q_cyc[idx],
                   8'(8'hE0 + k), 8'(8'h10 * k + 8'h05), n + (DEPTH + 2) * j + k);
        end
      end
    end
    tests_run++;
    if (d_cyc.size() - d0 !== 2 || d_cyc[d0] != n + DEPTH || d_cyc[d0+1] != n + 2 * DEPTH + 2) begin
      tests_failed++;
      $display("FAIL b2b_done: got %0d pulses required 2 at %0d and %0d",
               d_cyc.size() - d0, n + DEPTH, n + 2 * DEPTH + 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_snapshot();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_line_loader
